// File: rtl/cordic_req_sched_pkg.sv
// Shared definitions for the CORDIC request scheduler.
// Word widths, initial vector and FSM state encoding.
package cordic_defs;

  localparam int unsigned ANG_W = 18;
  localparam int unsigned DW    = 16;

  localparam logic [15:0] X_INIT = 16'h4000;
  localparam logic [15:0] Y_INIT = 16'h0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/cordic_req_sched_rr_arb2.sv
// Two-way round-robin arbiter, purely combinational.
// The prio input names the requester that wins a tie.
module rr_arb2 (
  input  logic valid0,
  input  logic valid1,
  input  logic prio,
  input  logic en,
  output logic ready0,
  output logic ready1,
  output logic grant
);

  assign ready0 = en && (!prio || !valid1);
  assign ready1 = en && (prio || !valid0);
  assign grant  = valid1 && ready1;

endmodule

// File: rtl/cordic_req_sched.sv
// Arbitrates angle requests into the CORDIC datapath and
// returns the settled cos/sin with the source tag.
module cordic_req_sched #(
  parameter int unsigned     ANG_W  = cordic_defs::ANG_W,
  parameter int unsigned     DW     = cordic_defs::DW,
  parameter int              SETTLE = 2,
  parameter logic [DW-1:0]   X_INIT = DW'(cordic_defs::X_INIT)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [ANG_W-1:0] req0_angle,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [ANG_W-1:0] req1_angle,
  output logic [ANG_W-1:0] dp_angle,
  output logic [DW-1:0]    dp_x,
  output logic [DW-1:0]    dp_y,
  input  logic [DW-1:0]    dp_xout,
  input  logic [DW-1:0]    dp_yout,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [DW-1:0]    res_cos,
  output logic [DW-1:0]    res_sin,
  output logic             res_src,
  output logic             busy
);

  import cordic_defs::*;

  localparam int CW = $clog2(SETTLE) + 1;

  if (SETTLE < 1) begin : g_settle_chk
    $error("SETTLE must be >= 1");
  end

  state_t        state;
  state_t        state_nx;
  logic          prio;
  logic          src;
  logic [CW-1:0] cnt;
  logic          idle;
  logic          grant;
  logic          accept;

  assign idle = (state == IDLE);
  assign busy = !idle;

  rr_arb2 u_arb (
    .valid0 (req0_valid),
    .valid1 (req1_valid),
    .prio   (prio),
    .en     (idle),
    .ready0 (req0_ready),
    .ready1 (req1_ready),
    .grant  (grant)
  );

  assign accept = (req0_valid && req0_ready)
               || (req1_valid && req1_ready);

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (accept)      state_nx = WAIT;
      WAIT:    if (cnt == '0)   state_nx = DONE;
      DONE:    if (res_ready)   state_nx = IDLE;
      default:                  state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dp_angle  <= '0;
      dp_x      <= '0;
      dp_y      <= '0;
      src       <= 1'b0;
      prio      <= 1'b0;
      cnt       <= '0;
      res_valid <= 1'b0;
      res_cos   <= '0;
      res_sin   <= '0;
      res_src   <= 1'b0;
    end else begin
      if (idle && accept) begin
        dp_angle <= grant ? req1_angle : req0_angle;
        dp_x     <= X_INIT;
        dp_y     <= DW'(Y_INIT);
        src      <= grant;
        cnt      <= CW'(SETTLE - 1);
        prio     <= ~grant;
      end
      // dp_xout/dp_yout are only trusted once the settle time has elapsed
      if (state == WAIT) begin
        if (cnt == '0) begin
          res_cos   <= dp_xout;
          res_sin   <= dp_yout;
          res_src   <= src;
          res_valid <= 1'b1;
        end else begin
          cnt <= cnt - CW'(1);
        end
      end
      if (state == DONE && res_ready) res_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cordic_req_sched.sv
// Randomized and directed bench for cordic_req_sched
// against a transaction-level reference model.
module tb_cordic_req_sched;

  localparam int S = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        req0_valid = 0, req1_valid = 0, res_ready = 0;
  logic [17:0] req0_angle = '0, req1_angle = '0;
  logic        req0_ready, req1_ready, res_valid, res_src, busy;
  logic [17:0] dp_angle;
  logic [15:0] dp_x, dp_y, dp_xout, dp_yout, res_cos, res_sin;

  function automatic logic [15:0] stub_x(input logic [17:0] a);
    if (a == 18'h15F97) return 16'h2D41;
    return a[15:0] ^ 16'h5A5A;
  endfunction

  function automatic logic [15:0] stub_y(input logic [17:0] a);
    if (a == 18'h15F97) return 16'h2D41;
    return {a[17:10], a[7:0]} + 16'd3;
  endfunction

  assign dp_xout = stub_x(dp_angle);
  assign dp_yout = stub_y(dp_angle);

  cordic_req_sched #(.SETTLE(S)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_angle(req0_angle),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_angle(req1_angle),
    .dp_angle(dp_angle), .dp_x(dp_x), .dp_y(dp_y),
    .dp_xout(dp_xout), .dp_yout(dp_yout),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_cos(res_cos), .res_sin(res_sin),
    .res_src(res_src), .busy(busy)
  );

  logic        v0_4 = 0, v1_4 = 0, rr_4 = 0;
  logic [17:0] a0_4 = '0, a1_4 = '0;
  logic        r0_4, r1_4, rv_4, rs_4, busy_4;
  logic [17:0] ang_4;
  logic [15:0] x_4, y_4, cos_4, sin_4;
  logic [15:0] xo_4 = '0, yo_4 = '0;

  cordic_req_sched #(.SETTLE(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(v0_4), .req0_ready(r0_4), .req0_angle(a0_4),
    .req1_valid(v1_4), .req1_ready(r1_4), .req1_angle(a1_4),
    .dp_angle(ang_4), .dp_x(x_4), .dp_y(y_4),
    .dp_xout(xo_4), .dp_yout(yo_4),
    .res_valid(rv_4), .res_ready(rr_4),
    .res_cos(cos_4), .res_sin(sin_4),
    .res_src(rs_4), .busy(busy_4)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // transaction-level model: one job in flight, result after S edges
  bit          m_busy, m_rv, m_prio, m_src, m_rsrc, m_gv, m_g;
  logic [17:0] m_angle;
  logic [15:0] m_dpx, m_dpy, m_rcos, m_rsin;
  int          m_left;

  bit          dv0, dv1;
  logic [17:0] da0, da1;
  int          cyc = 0;
  int          obs_src[$];
  int          obs_cyc[$];

  task automatic model_reset();
    m_busy = 0; m_rv = 0; m_prio = 0; m_src = 0; m_rsrc = 0;
    m_angle = '0; m_dpx = '0; m_dpy = '0;
    m_rcos = '0; m_rsin = '0; m_left = 0; m_gv = 0; m_g = 0;
  endtask

  task automatic step(input logic rr);
    bit e_r0, e_r1;
    req0_valid = dv0; req0_angle = da0;
    req1_valid = dv1; req1_angle = da1;
    res_ready  = rr;
    #3;
    e_r0 = !m_busy && (!m_prio || !dv1);
    e_r1 = !m_busy && (m_prio || !dv0);
    check("req0_ready", req0_ready, e_r0);
    check("req1_ready", req1_ready, e_r1);
    check("busy", busy, m_busy);
    check("res_valid", res_valid, m_rv);
    check("dp_angle", dp_angle, m_angle);
    check("dp_x", dp_x, m_dpx);
    check("dp_y", dp_y, m_dpy);
    check("res_cos", res_cos, m_rcos);
    check("res_sin", res_sin, m_rsin);
    check("res_src", res_src, m_rsrc);
    if (res_valid && res_ready) begin
      obs_src.push_back(int'(res_src));
      obs_cyc.push_back(cyc);
    end
    m_gv = 0;
    if (!rst_n) begin
      model_reset();
    end else if (!m_busy) begin
      if ((dv0 && e_r0) || (dv1 && e_r1)) begin
        m_gv = 1;
        m_g = !(dv0 && e_r0);
        m_angle = m_g ? da1 : da0;
        m_dpx = 16'h4000; m_dpy = '0;
        m_src = m_g; m_prio = !m_g;
        m_busy = 1; m_left = S;
      end
    end else if (!m_rv) begin
      m_left--;
      if (m_left == 0) begin
        m_rv = 1; m_rsrc = m_src;
        m_rcos = stub_x(m_angle); m_rsin = stub_y(m_angle);
      end
    end else if (rr) begin
      m_rv = 0; m_busy = 0;
    end
    cyc++;
    @(posedge clk); #1;
    if (m_gv && !m_g) dv0 = 0;
    if (m_gv && m_g) dv1 = 0;
  endtask

  task automatic async_reset_check(input string tag);
    rst_n = 0;
    #1;
    check({tag, "_valid"}, res_valid, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_angle"}, dp_angle, 0);
    check({tag, "_x"}, dp_x, 0);
    check({tag, "_cos"}, res_cos, 0);
    model_reset();
  endtask

  logic [17:0] sav_a;
  logic [15:0] sav_c;

  initial begin
    model_reset();
    dv0 = 0; dv1 = 0; da0 = '0; da1 = '0;
    #1;
    // reset with random inputs
    for (int i = 0; i < 4; i++) begin
      dv0 = 1'($urandom()); dv1 = 1'($urandom());
      da0 = 18'($urandom()); da1 = 18'($urandom());
      step(1'($urandom()));
    end
    rst_n = 1;
    dv0 = 0; dv1 = 0;

    // single request
    dv0 = 1; da0 = 18'h15F97;
    step(1);
    check("single_angle", dp_angle, 18'h15F97);
    check("single_x", dp_x, 16'h4000);
    check("single_y", dp_y, 16'h0000);
    check("single_early", res_valid, 0);
    step(0);
    check("single_k1", res_valid, 0);
    step(0);
    check("single_k2", res_valid, 1);
    check("single_cos", res_cos, 16'h2D41);
    check("single_sin", res_sin, 16'h2D41);
    check("single_src", res_src, 0);
    step(1);

    // contention from a fresh reset (prio=0)
    async_reset_check("rst_a");
    step(0);
    rst_n = 1;
    obs_src.delete(); obs_cyc.delete();
    for (int i = 0; i < 20; i++) begin
      if (!dv0) begin dv0 = 1; da0 = 18'($urandom()); end
      if (!dv1) begin dv1 = 1; da1 = 18'($urandom()); end
      step(1);
    end
    check("cont_count", obs_src.size() >= 4, 1);
    for (int i = 0; i < 4 && i < obs_src.size(); i++)
      check($sformatf("cont_src%0d", i), obs_src[i], i % 2);
    for (int i = 1; i < 4 && i < obs_cyc.size(); i++)
      check($sformatf("cont_gap%0d", i),
            obs_cyc[i] - obs_cyc[i-1], 4);

    // backpressure
    dv0 = 0; dv1 = 0;
    for (int i = 0; i < 10 && busy; i++) step(1);
    check("bp_idle", busy, 0);
    dv1 = 1; da1 = 18'($urandom());
    for (int i = 0; i < 10 && !res_valid; i++) step(0);
    check("bp_done", res_valid, 1);
    sav_c = res_cos;
    dv0 = 1; da0 = 18'($urandom()); sav_a = da0;
    for (int i = 0; i < 5; i++) step(0);
    check("bp_hold", res_cos, sav_c);
    check("bp_noacc", dv0, 1);
    step(1);
    check("bp_idle2", busy, 0);
    step(1);
    check("bp_acc", busy, 1);
    check("bp_acc_angle", dp_angle, sav_a);

    // async reset mid-cycle while presenting a result
    for (int i = 0; i < 10 && !res_valid; i++) step(0);
    check("ar_done", res_valid, 1);
    #2;
    async_reset_check("rst_b");
    step(0);
    step(0);
    rst_n = 1;

    // reset one edge into the settle window
    dv0 = 1; dv1 = 0; da0 = 18'($urandom());
    step(1);
    step(0);
    async_reset_check("rst_w");
    for (int i = 0; i < 3; i++) step(1);
    rst_n = 1;
    dv1 = 1; da1 = 18'($urandom()); sav_a = da1;
    step(1);
    check("mw_served", busy, 1);
    check("mw_angle", dp_angle, sav_a);
    for (int i = 0; i < 6; i++) step(1);

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      if (!dv0) begin
        if ($urandom_range(0, 1) == 1) begin
          dv0 = 1; da0 = 18'($urandom());
        end
      end else if ($urandom_range(0, 15) == 0) dv0 = 0;
      if (!dv1) begin
        if ($urandom_range(0, 1) == 1) begin
          dv1 = 1; da1 = 18'($urandom());
        end
      end else if ($urandom_range(0, 15) == 0) dv1 = 0;
      step(1'($urandom_range(0, 3) != 0));
    end

    // SETTLE=4 capture timing
    dv0 = 0; dv1 = 0;
    req0_valid = 0; req1_valid = 0;
    v0_4 = 1; a0_4 = 18'h0ABCD; xo_4 = 16'h1111; yo_4 = 16'h2222;
    #3;
    check("s4_ready", r0_4, 1);
    @(posedge clk); #1;
    v0_4 = 0;
    check("s4_busy", busy_4, 1);
    check("s4_angle", ang_4, 18'h0ABCD);
    @(posedge clk); #1;
    @(posedge clk); #1;
    xo_4 = 16'h3333; yo_4 = 16'h4444;
    check("s4_k2", rv_4, 0);
    @(posedge clk); #1;
    check("s4_k3", rv_4, 0);
    @(posedge clk); #1;
    xo_4 = 16'h5555; yo_4 = 16'h6666;
    check("s4_k4", rv_4, 1);
    check("s4_cos", cos_4, 16'h3333);
    check("s4_sin", sin_4, 16'h4444);
    @(posedge clk); #1;
    check("s4_hold", cos_4, 16'h3333);
    rr_4 = 1;
    @(posedge clk); #1;
    check("s4_release", rv_4, 0);
    check("s4_idle", busy_4, 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
